// File: rtl/ex_stage_md_pkg.sv
// Shared definitions for the execute-stage multiply/divide back end.
// Contents: M-extension funct3 encodings, md_unit FSM state encoding,
//           and the active levels of the hazard controller's hold/flush.
package ex_stage_md_pkg;

  // M-extension funct3 encodings
  localparam logic [2:0] MD_OP_MUL    = 3'd0;
  localparam logic [2:0] MD_OP_MULH   = 3'd1;
  localparam logic [2:0] MD_OP_MULHSU = 3'd2;
  localparam logic [2:0] MD_OP_MULHU  = 3'd3;
  localparam logic [2:0] MD_OP_DIV    = 3'd4;
  localparam logic [2:0] MD_OP_DIVU   = 3'd5;
  localparam logic [2:0] MD_OP_REM    = 3'd6;
  localparam logic [2:0] MD_OP_REMU   = 3'd7;

  // md_unit FSM states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Active levels of the hazard-controller strobes
  localparam logic HOLD_ACTIVE  = 1'b1;
  localparam logic FLUSH_ACTIVE = 1'b1;

endpackage

// File: rtl/ex_stage_md_md_unit.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit.
// Ports: start/op/rs1/rs2 launch an op from IDLE; flush aborts to IDLE; hold
//        parks a finished result in DONE; busy = not IDLE; done/result in DONE.
module md_unit
  import ex_stage_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q;
  // Multiply: {high partial sum, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend/quotient shift register}.
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;   // multiplicand or divisor magnitude
  logic [2:0]        op_q;
  logic              qneg_q;   // negate product / quotient
  logic              rneg_q;   // negate remainder

  logic              flush_act, hold_act;
  logic              is_div, s1_signed, s2_signed, neg1, neg2;
  logic [XLEN-1:0]   abs1, abs2;
  logic              div_zero, div_ovf, fast;

  assign flush_act = (flush == FLUSH_ACTIVE);
  assign hold_act  = (hold == HOLD_ACTIVE);

  // Operand decode
  assign is_div    = op[2];
  assign s1_signed = !(op == MD_OP_MULHU || op == MD_OP_DIVU || op == MD_OP_REMU);
  assign s2_signed = (op == MD_OP_MUL) || (op == MD_OP_MULH) ||
                     (op == MD_OP_DIV) || (op == MD_OP_REM);
  assign neg1      = s1_signed & rs1[XLEN-1];
  assign neg2      = s2_signed & rs2[XLEN-1];
  assign abs1      = neg1 ? (~rs1 + 1'b1) : rs1;
  assign abs2      = neg2 ? (~rs2 + 1'b1) : rs2;
  assign div_zero  = is_div & (rs2 == '0);
  assign div_ovf   = ((op == MD_OP_DIV) || (op == MD_OP_REM)) &&
                     (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
  assign fast      = div_zero | div_ovf;

  // One shift-add multiply step; the extra sum bit carries into the shift.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring divide step.
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_next;
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: begin
        if (!flush_act && start) state_d = fast ? MD_DONE : MD_BUSY;
      end
      MD_BUSY: begin
        if (flush_act)          state_d = MD_IDLE;
        else if (cnt_q == '0)   state_d = MD_DONE;
      end
      MD_DONE: begin
        if (flush_act)          state_d = MD_IDLE;
        else if (!hold_act)     state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == MD_IDLE && start && !flush_act) begin
        op_q <= op;
        cnt_q <= CW'(XLEN-1);
        if (fast) begin
          // Fast results are loaded directly; no sign fix-up afterwards.
          acc_q  <= div_zero ? {rs1, {XLEN{1'b1}}} : {{XLEN{1'b0}}, rs1};
          opnd_q <= '0;
          qneg_q <= 1'b0;
          rneg_q <= 1'b0;
        end else begin
          acc_q  <= {{XLEN{1'b0}}, is_div ? abs1 : abs2};
          opnd_q <= is_div ? abs2 : abs1;
          qneg_q <= neg1 ^ neg2;
          rneg_q <= neg1;
        end
      end else if (state_q == MD_BUSY) begin
        acc_q <= op_q[2] ? div_next : mul_next;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Final sign correction, applied while the result sits in DONE.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  assign prod = qneg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo  = acc_q[XLEN-1:0];
  assign rem  = acc_q[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    unique case (op_q)
      MD_OP_MUL:                            result = prod[XLEN-1:0];
      MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: result = prod[2*XLEN-1:XLEN];
      MD_OP_DIV, MD_OP_DIVU:                result = qneg_q ? (~quo + 1'b1) : quo;
      MD_OP_REM, MD_OP_REMU:                result = rneg_q ? (~rem + 1'b1) : rem;
      default:                              result = '0;
    endcase
  end

  assign busy = (state_q != MD_IDLE);
  assign done = (state_q == MD_DONE);

endmodule

// File: rtl/ex_stage_md.sv
// Execute-stage back end: EX/MEM pipeline register, ALU/M-result mux, stall.
// Ports: ALU result and M operands in; EX/MEM dest/data/enable out; stall_o is
//        combinational (M op in EX not yet done); hold_i freezes, flush_i bubbles.
module ex_stage_md
  import ex_stage_md_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic                  md_en_i,
  input  logic [2:0]            md_op_i,
  input  logic [XLEN-1:0]       rs1_i,
  input  logic [XLEN-1:0]       rs2_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic [REG_ADDR_W-1:0] addr_reg_wr_i,
  input  logic                  reg_wr_en_i,
  output logic                  stall_o,
  output logic [REG_ADDR_W-1:0] addr_reg_wr_o,
  output logic [XLEN-1:0]       data_reg_wr_o,
  output logic                  reg_wr_en_o,
  output logic                  md_busy_o
);

  logic            md_sel, md_done, md_busy;
  logic [XLEN-1:0] md_result;

  assign md_sel = valid_i & md_en_i;

  md_unit #(.XLEN(XLEN)) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_sel),
    .op     (md_op_i),
    .rs1    (rs1_i),
    .rs2    (rs2_i),
    .flush  (flush_i),
    .hold   (hold_i),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // Released in DONE so upstream advances on the edge that commits the result.
  assign stall_o   = md_sel & ~md_done;
  assign md_busy_o = md_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg_wr_o <= '0;
      data_reg_wr_o <= '0;
      reg_wr_en_o   <= 1'b0;
    end else if (flush_i == FLUSH_ACTIVE) begin
      addr_reg_wr_o <= '0;
      data_reg_wr_o <= '0;
      reg_wr_en_o   <= 1'b0;
    end else if (hold_i != HOLD_ACTIVE) begin
      if (md_sel) begin
        if (md_done) begin
          addr_reg_wr_o <= addr_reg_wr_i;
          data_reg_wr_o <= md_result;
          reg_wr_en_o   <= valid_i & reg_wr_en_i;
        end else begin
          // M op still iterating: nothing may reach writeback yet.
          addr_reg_wr_o <= '0;
          data_reg_wr_o <= '0;
          reg_wr_en_o   <= 1'b0;
        end
      end else begin
        addr_reg_wr_o <= addr_reg_wr_i;
        data_reg_wr_o <= alu_result_i;
        reg_wr_en_o   <= valid_i & reg_wr_en_i;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Testbench for ex_stage_md (XLEN=32): table of M-op vectors with hand-computed
// results and stall lengths, plus directed flush / hold / reset sequences.
module tb_ex_stage_md;
  import ex_stage_md_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst_n, hold_i, flush_i, valid_i, md_en_i, reg_wr_en_i;
  logic [2:0]      md_op_i;
  logic [XLEN-1:0] rs1_i, rs2_i, alu_result_i;
  logic [RW-1:0]   addr_reg_wr_i;
  logic            stall_o, reg_wr_en_o, md_busy_o;
  logic [RW-1:0]   addr_reg_wr_o;
  logic [XLEN-1:0] data_reg_wr_o;

  ex_stage_md #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold_i        (hold_i),
    .flush_i       (flush_i),
    .valid_i       (valid_i),
    .md_en_i       (md_en_i),
    .md_op_i       (md_op_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .alu_result_i  (alu_result_i),
    .addr_reg_wr_i (addr_reg_wr_i),
    .reg_wr_en_i   (reg_wr_en_i),
    .stall_o       (stall_o),
    .addr_reg_wr_o (addr_reg_wr_o),
    .data_reg_wr_o (data_reg_wr_o),
    .reg_wr_en_o   (reg_wr_en_o),
    .md_busy_o     (md_busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int         stalls;
  } vec_t;

  vec_t vecs[18];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 0; md_en_i = 0; hold_i = 0; flush_i = 0; md_op_i = 0;
    rs1_i = 0; rs2_i = 0; alu_result_i = 0; addr_reg_wr_i = 0; reg_wr_en_i = 0;
  endtask

  function automatic vec_t mk(input string n, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] e, input int s);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.exp = e; v.stalls = s;
    return v;
  endfunction

  // Present an M op, count stall cycles until DONE, then check the commit.
  task automatic run_md(input vec_t v, input int idx);
    int stalls;
    valid_i = 1; md_en_i = 1; md_op_i = v.op; rs1_i = v.a; rs2_i = v.b;
    alu_result_i = 32'hDEADBEEF; addr_reg_wr_i = RW'(idx + 1); reg_wr_en_i = 1;
    #1;
    stalls = 0;
    while (stall_o && stalls <= 100) begin
      stalls++;
      tick();
    end
    check({v.name, " stall cycles"}, 64'(stalls), 64'(v.stalls));
    check({v.name, " busy in DONE"}, 64'(md_busy_o), 64'd1);
    tick();
    check({v.name, " data"}, 64'(data_reg_wr_o), 64'(v.exp));
    check({v.name, " wr_en"}, 64'(reg_wr_en_o), 64'd1);
    check({v.name, " addr"}, 64'(addr_reg_wr_o), 64'(idx + 1));
    idle_inputs();
  endtask

  initial begin
    vecs[0]  = mk("MUL 7*-3",        MD_OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    vecs[1]  = mk("MULH min*min",    MD_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
    vecs[2]  = mk("MULHU 8e7*8e7",   MD_OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 33);
    vecs[3]  = mk("MULHSU -1*2",     MD_OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    vecs[4]  = mk("DIV -7/2",        MD_OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    vecs[5]  = mk("REM -7/2",        MD_OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    vecs[6]  = mk("DIVU 7/2",        MD_OP_DIVU,   32'd7,        32'd2,        32'd3,        33);
    vecs[7]  = mk("DIV 5/0",         MD_OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    vecs[8]  = mk("REM 5/0",         MD_OP_REM,    32'd5,        32'd0,        32'd5,        1);
    vecs[9]  = mk("DIV min/-1",      MD_OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    vecs[10] = mk("REM min/-1",      MD_OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    vecs[11] = mk("REMU 100/7",      MD_OP_REMU,   32'd100,      32'd7,        32'd2,        33);
    vecs[12] = mk("MUL shift4",      MD_OP_MUL,    32'h12345678, 32'h10,       32'h23456780, 33);
    vecs[13] = mk("DIVU 5/0",        MD_OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    vecs[14] = mk("REMU -1/0",       MD_OP_REMU,   32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1);
    vecs[15] = mk("MULHU max*max",   MD_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    vecs[16] = mk("MULH -1*-1",      MD_OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        33);
    vecs[17] = mk("DIV -7/-2",       MD_OP_DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        33);

    // Reset state
    rst_n = 0;
    idle_inputs();
    #12;
    check("reset data", 64'(data_reg_wr_o), 64'd0);
    check("reset wr_en", 64'(reg_wr_en_o), 64'd0);
    check("reset addr", 64'(addr_reg_wr_o), 64'd0);
    check("reset busy", 64'(md_busy_o), 64'd0);
    check("reset stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    rst_n = 1;
    tick();

    // Non-M op: one-cycle latency
    valid_i = 1; alu_result_i = 32'h0BADF00D; addr_reg_wr_i = 5'd12; reg_wr_en_i = 1;
    #1;
    check("alu stall", 64'(stall_o), 64'd0);
    tick();
    check("alu data", 64'(data_reg_wr_o), 64'h0BADF00D);
    check("alu wr_en", 64'(reg_wr_en_o), 64'd1);
    check("alu addr", 64'(addr_reg_wr_o), 64'd12);
    valid_i = 0;
    tick();
    check("bubble wr_en", 64'(reg_wr_en_o), 64'd0);

    // Table of M ops
    for (int i = 0; i < 18; i++) run_md(vecs[i], i);

    // Flush in BUSY cycle 10, then an ADD commits with 1-cycle latency
    valid_i = 1; md_en_i = 1; md_op_i = MD_OP_MUL; rs1_i = 7; rs2_i = 3;
    reg_wr_en_i = 1; addr_reg_wr_i = 5'd9;
    #1;
    check("flush seq stall c0", 64'(stall_o), 64'd1);
    repeat (10) tick();
    check("flush seq busy c10", 64'(md_busy_o), 64'd1);
    check("flush seq stall c10", 64'(stall_o), 64'd1);
    flush_i = 1;
    tick();
    check("flush wr_en", 64'(reg_wr_en_o), 64'd0);
    check("flush data", 64'(data_reg_wr_o), 64'd0);
    check("flush addr", 64'(addr_reg_wr_o), 64'd0);
    check("flush busy", 64'(md_busy_o), 64'd0);
    flush_i = 0; md_en_i = 0; alu_result_i = 32'hA5A5A5A5; addr_reg_wr_i = 5'd3;
    #1;
    check("post-flush stall", 64'(stall_o), 64'd0);
    tick();
    check("post-flush add data", 64'(data_reg_wr_o), 64'hA5A5A5A5);
    check("post-flush add wr_en", 64'(reg_wr_en_o), 64'd1);
    check("post-flush add addr", 64'(addr_reg_wr_o), 64'd3);
    idle_inputs();
    tick();

    // hold_i for 3 cycles starting in DONE
    begin
      int n;
      valid_i = 1; md_en_i = 1; md_op_i = MD_OP_DIVU; rs1_i = 7; rs2_i = 2;
      reg_wr_en_i = 1; addr_reg_wr_i = 5'd4;
      #1;
      n = 0;
      while (stall_o && n <= 100) begin
        n++;
        tick();
      end
      check("hold seq stall cycles", 64'(n), 64'd33);
      hold_i = 1;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("hold busy", 64'(md_busy_o), 64'd1);
        check("hold stall", 64'(stall_o), 64'd0);
        check("hold no write", 64'(reg_wr_en_o), 64'd0);
      end
      hold_i = 0;
      tick();
      check("hold release data", 64'(data_reg_wr_o), 64'd3);
      check("hold release wr_en", 64'(reg_wr_en_o), 64'd1);
      check("hold release addr", 64'(addr_reg_wr_o), 64'd4);
      check("hold release busy", 64'(md_busy_o), 64'd0);
      idle_inputs();
      tick();
    end

    // Asynchronous reset mid-BUSY; EX/MEM held at a known non-zero value first
    valid_i = 1; alu_result_i = 32'h77; addr_reg_wr_i = 5'd7; reg_wr_en_i = 1;
    tick();
    check("pre-reset alu data", 64'(data_reg_wr_o), 64'h77);
    hold_i = 1; md_en_i = 1; md_op_i = MD_OP_MUL; rs1_i = 5; rs2_i = 6;
    repeat (5) tick();
    check("hold freezes exmem", 64'(data_reg_wr_o), 64'h77);
    check("busy before reset", 64'(md_busy_o), 64'd1);
    #3;
    rst_n = 0;
    #1;
    check("async reset data", 64'(data_reg_wr_o), 64'd0);
    check("async reset wr_en", 64'(reg_wr_en_o), 64'd0);
    check("async reset addr", 64'(addr_reg_wr_o), 64'd0);
    check("async reset busy", 64'(md_busy_o), 64'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    repeat (3) tick();
    check("after reset busy", 64'(md_busy_o), 64'd0);
    check("after reset no write", 64'(reg_wr_en_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
